alu_word_sequencer: RTL

- Multi-byte arithmetic/logic controller that sequences the team's 8-bit ALU over NBYTES byte slices, LSB first.
- Chains carry/borrow between slices and accumulates a wide result plus carry and zero flags.
- Sits between the control unit and one external 8-bit ALU instance, which the parent wires to the alu* ports.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_word_sequencer_byte_slicer.sv | 49 ++++
 rtl/alu_word_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for alu_word_sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/alu_word_sequencer_byte_slicer.sv
// alu_byte_slicer: selects byte idx of the latched operands and maps the word
// opcode/carry onto the per-byte ALU operation. Drives zeros when not active.
module alu_byte_slicer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IDXW   = 2
) (
  input  logic                  active,
  input  logic [IDXW-1:0]       idx,
  input  logic [2:0]            op,
  input  logic                  cin,
  input  logic                  chain,
  input  logic [8*NBYTES-1:0]   a_word,
  input  logic [8*NBYTES-1:0]   b_word,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [2:0]            alu_op,
  output logic                  alu_cin
);

  // Byte select plus opcode/carry mapping; upper arithmetic bytes always chain.
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_op  = OP_ADD;
    alu_cin = 1'b0;
    if (active) begin
      alu_a = a_word[{idx, 3'b000} +: 8];
      alu_b = b_word[{idx, 3'b000} +: 8];
      if (idx == {IDXW{1'b0}}) begin
        alu_op  = op;
        alu_cin = ((op == OP_ADC) || (op == OP_SBC)) ? cin : 1'b0;
      end else if (is_arith(op)) begin
        alu_op  = op[1] ? OP_SBC : OP_ADC;
        alu_cin = chain;
      end else begin
        alu_op  = op;
        alu_cin = 1'b0;
      end
    end else begin
      alu_a   = 8'h00;
      alu_b   = 8'h00;
      alu_op  = OP_ADD;
      alu_cin = 1'b0;
    end
  end

endmodule

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs an external 8-bit ALU over NBYTES slices, LSB first,
// chaining carry/borrow. Define ALU_SEQ_OVERFLOW_EN to add the signed overflow output.
module alu_word_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic                  carryIn,
  input  logic [8*NBYTES-1:0]   operandA,
  input  logic [8*NBYTES-1:0]   operandB,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carryOut,
  output logic                  zero,
  output logic [7:0]            aluInputA,
  output logic [7:0]            aluInputB,
  output logic                  aluCarryIn,
  output logic [2:0]            aluOperation,
  input  logic [7:0]            aluResult,
  input  logic                  aluCarryOut,
  input  logic                  aluZero
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             chain_q, chain_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             overflow_q, overflow_d;
`endif

  // The word zero flag is computed locally; the per-byte ALU flag is not needed.
  logic unused_alu_zero;
  assign unused_alu_zero = aluZero;

  alu_byte_slicer #(
    .NBYTES (NBYTES),
    .IDXW   (IDXW)
  ) u_slicer (
    .active  (state_q == EXEC),
    .idx     (idx_q),
    .op      (op_q),
    .cin     (cin_q),
    .chain   (chain_q),
    .a_word  (a_q),
    .b_word  (b_q),
    .alu_a   (aluInputA),
    .alu_b   (aluInputB),
    .alu_op  (aluOperation),
    .alu_cin (aluCarryIn)
  );

  // Next-state, operand latching and result/flag accumulation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    cin_d       = cin_q;
    a_d         = a_q;
    b_d         = b_q;
    chain_d     = chain_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    overflow_d  = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = opcode;
          cin_d    = carryIn;
          a_d      = operandA;
          b_d      = operandB;
          result_d = {W{1'b0}};
          chain_d  = 1'b0;
          idx_d    = {IDXW{1'b0}};
          state_d  = EXEC;
        end else begin
          state_d  = IDLE;
        end
      end
      EXEC: begin
        result_d[{idx_q, 3'b000} +: 8] = aluResult;
        chain_d = is_arith(op_q) ? aluCarryOut : 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          carry_out_d = chain_d;
          zero_d      = (result_d == {W{1'b0}});
`ifdef ALU_SEQ_OVERFLOW_EN
          if (!is_arith(op_q)) begin
            overflow_d = 1'b0;
          end else if (op_q[1]) begin
            overflow_d = (a_q[W-1] != b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
          end else begin
            overflow_d = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
          end
`endif
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {IDXW{1'b0}};
      op_q        <= 3'b000;
      cin_q       <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      chain_q     <= 1'b0;
      result_q    <= {W{1'b0}};
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      a_q         <= a_d;
      b_q         <= b_d;
      chain_q     <= chain_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ALU_SEQ_OVERFLOW_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carryOut = carry_out_q;
  assign zero     = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
  assign overflow = overflow_q;
`endif

endmodule
